// File: rtl/imem_loader_if.sv
// Byte-stream input, memory write port and status bundle for imem_loader.
// The slave modport is the loader; the master modport is the byte source / controller.
interface imem_loader_if #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_BITS  = 10
);
  logic                  i_start;
  logic                  i_abort;
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  o_ready;
  logic                  o_write_enable;
  logic [ADDR_BITS-1:0]  o_write_addr;
  logic [WORD_WIDTH-1:0] o_data;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_overrun;
  logic [ADDR_BITS:0]    o_word_count;

  modport master (
    output i_start, i_abort, i_rx_data, i_rx_valid,
    input  o_ready, o_write_enable, o_write_addr, o_data,
    input  o_busy, o_done, o_overrun, o_word_count
  );

  modport slave (
    input  i_start, i_abort, i_rx_data, i_rx_valid,
    output o_ready, o_write_enable, o_write_addr, o_data,
    output o_busy, o_done, o_overrun, o_word_count
  );
endinterface

// File: rtl/imem_loader.sv
// Fills an instruction memory from a byte stream: bytes are packed MSB-first into
// words and written to ascending addresses until a halt word or the last address.
module imem_loader #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter int unsigned           ADDR_BITS  = 10,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD  = '1
) (
  input logic          i_clock,
  input logic          i_reset,
  imem_loader_if.slave bus
);

  localparam int unsigned BYTES = WORD_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(BYTES) + 1;
  localparam int unsigned WC_W  = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q,  state_d;
  logic [ADDR_BITS-1:0]  addr_q,   addr_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [WORD_WIDTH-1:0] word_q,   word_d;
  logic [WORD_WIDTH-1:0] shifted;

  logic                  we_d;
  logic [ADDR_BITS-1:0]  waddr_d;
  logic [WORD_WIDTH-1:0] data_d;
  logic                  ready_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  ovr_d;
  logic [WC_W-1:0]       wcnt_d;

  // Truncating the concatenation keeps {word[W-9:0], byte} for any byte-multiple width.
  assign shifted = WORD_WIDTH'({word_q, bus.i_rx_data});

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    waddr_d = bus.o_write_addr;
    data_d  = bus.o_data;
    ovr_d   = bus.o_overrun;
    wcnt_d  = bus.o_word_count;

    if (bus.i_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            state_d = S_RECV;
            addr_d  = '0;
            cnt_d   = '0;
            wcnt_d  = '0;
            ovr_d   = 1'b0;
          end
        end
        S_RECV: begin
          if (bus.i_rx_valid) begin
            word_d = shifted;
            if (cnt_q == LAST_BYTE) begin
              state_d = S_WRITE;
              cnt_d   = '0;
              waddr_d = addr_q;
              data_d  = shifted;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          wcnt_d = bus.o_word_count + WC_W'(1);
          if (bus.i_rx_valid) ovr_d = 1'b1;
          // Stop on halt word or at the last address; the address never wraps.
          if (word_q == HALT_WORD || addr_q == '1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RECV;
            addr_d  = addr_q + ADDR_BITS'(1);
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Status outputs are registered copies of the next state's decode.
    ready_d = (state_d == S_RECV);
    busy_d  = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    we_d    = (state_d == S_WRITE);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q            <= S_IDLE;
      addr_q             <= '0;
      cnt_q              <= '0;
      word_q             <= '0;
      bus.o_write_enable <= 1'b0;
      bus.o_write_addr   <= '0;
      bus.o_data         <= '0;
      bus.o_ready        <= 1'b0;
      bus.o_busy         <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_overrun      <= 1'b0;
      bus.o_word_count   <= '0;
    end else begin
      state_q            <= state_d;
      addr_q             <= addr_d;
      cnt_q              <= cnt_d;
      word_q             <= word_d;
      bus.o_write_enable <= we_d;
      bus.o_write_addr   <= waddr_d;
      bus.o_data         <= data_d;
      bus.o_ready        <= ready_d;
      bus.o_busy         <= busy_d;
      bus.o_done         <= done_d;
      bus.o_overrun      <= ovr_d;
      bus.o_word_count   <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 10-bit-address instance and a 2-bit-address instance,
// with expected memory writes queued by the stimulus and checked by a write monitor.
module tb_imem_loader;

  logic clk;
  logic rst_n;

  imem_loader_if #(.WORD_WIDTH(32), .ADDR_BITS(10)) bus1 ();
  imem_loader_if #(.WORD_WIDTH(32), .ADDR_BITS(2))  bus2 ();

  imem_loader #(.WORD_WIDTH(32), .ADDR_BITS(10)) dut1 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus1.slave)
  );

  imem_loader #(.WORD_WIDTH(32), .ADDR_BITS(2)) dut2 (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus2.slave)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  int  checks = 0;
  int  errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic ab,
                       input logic v, input logic [7:0] d);
    if (sel == 1) begin
      bus1.i_start = st; bus1.i_abort = ab; bus1.i_rx_valid = v; bus1.i_rx_data = d;
    end else begin
      bus2.i_start = st; bus2.i_abort = ab; bus2.i_rx_valid = v; bus2.i_rx_data = d;
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b1, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Strobe a byte immediately (used to hit the WRITE cycle).
  task automatic strobe_now(input int sel, input logic [7:0] b);
    drive(sel, 1'b0, 1'b0, 1'b1, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pulse(input int sel, input logic st, input logic ab);
    @(posedge clk); #1;
    drive(sel, st, ab, 1'b0, 8'h00);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input logic [31:0] exp_addr);
    wr_t e;
    e.addr = exp_addr;
    e.data = w;
    if (sel == 1) q1.push_back(e); else q2.push_back(e);
    send_byte(sel, w[31:24]);
    send_byte(sel, w[23:16]);
    send_byte(sel, w[15:8]);
    send_byte(sel, w[7:0]);
  endtask

  // Write monitor: every write-enable cycle must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (bus1.o_write_enable === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_write unexpected: addr=%0h data=%0h", bus1.o_write_addr, bus1.o_data);
      end else begin
        e = q1.pop_front();
        if (32'(bus1.o_write_addr) !== e.addr || bus1.o_data !== e.data) begin
          errors++;
          $display("FAIL dut1_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   bus1.o_write_addr, bus1.o_data, e.addr, e.data);
        end
      end
    end
    if (bus2.o_write_enable === 1'b1) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_write unexpected: addr=%0h data=%0h", bus2.o_write_addr, bus2.o_data);
      end else begin
        e = q2.pop_front();
        if (32'(bus2.o_write_addr) !== e.addr || bus2.o_data !== e.data) begin
          errors++;
          $display("FAIL dut2_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                   bus2.o_write_addr, bus2.o_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    64'(bus1.o_write_enable), 64'd0);
    check({tag, "_addr"},  64'(bus1.o_write_addr),   64'd0);
    check({tag, "_data"},  64'(bus1.o_data),         64'd0);
    check({tag, "_ready"}, 64'(bus1.o_ready),        64'd0);
    check({tag, "_busy"},  64'(bus1.o_busy),         64'd0);
    check({tag, "_done"},  64'(bus1.o_done),         64'd0);
    check({tag, "_ovr"},   64'(bus1.o_overrun),      64'd0);
    check({tag, "_wcnt"},  64'(bus1.o_word_count),   64'd0);
  endtask

  initial begin
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(2, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_dut2_done", 64'(bus2.o_done), 64'd0);
    rst_n = 1'b1;

    // Single word, then back in RECV
    pulse(1, 1'b1, 1'b0);
    check("start_ready", 64'(bus1.o_ready), 64'd1);
    check("start_busy",  64'(bus1.o_busy),  64'd1);
    send_word(1, 32'h12345678, 32'd0);
    check("write_pulse_we", 64'(bus1.o_write_enable), 64'd1);
    @(posedge clk); #1;
    check("w1_wcnt",  64'(bus1.o_word_count),   64'd1);
    check("w1_ready", 64'(bus1.o_ready),        64'd1);
    check("w1_we_off", 64'(bus1.o_write_enable), 64'd0);
    check("w1_hold_data", 64'(bus1.o_data), 64'h12345678);

    // Three words plus halt word
    pulse(1, 1'b0, 1'b1);
    pulse(1, 1'b1, 1'b0);
    send_word(1, 32'hDEADBEEF, 32'd0);
    send_word(1, 32'h00000001, 32'd1);
    send_word(1, 32'hCAFEF00D, 32'd2);
    send_word(1, 32'hFFFFFFFF, 32'd3);
    @(posedge clk); #1;
    check("halt_done",  64'(bus1.o_done),       64'd1);
    check("halt_wcnt",  64'(bus1.o_word_count), 64'd4);
    check("halt_busy",  64'(bus1.o_busy),       64'd0);
    check("halt_ready", 64'(bus1.o_ready),      64'd0);
    send_byte(1, 8'h55);
    check("done_no_ovr", 64'(bus1.o_overrun), 64'd0);

    // Byte strobed during WRITE sets sticky overrun and is dropped
    pulse(1, 1'b1, 1'b0);
    check("restart_done", 64'(bus1.o_done), 64'd0);
    send_word(1, 32'h01020304, 32'd0);
    strobe_now(1, 8'h99);
    check("ovr_set", 64'(bus1.o_overrun), 64'd1);
    send_word(1, 32'h05060708, 32'd1);
    @(posedge clk); #1;
    check("ovr_sticky", 64'(bus1.o_overrun),   64'd1);
    check("ovr_wcnt",   64'(bus1.o_word_count), 64'd2);

    // Abort mid-word, then a fresh load
    send_byte(1, 8'h11);
    send_byte(1, 8'h22);
    pulse(1, 1'b0, 1'b1);
    check("abort_busy",  64'(bus1.o_busy),       64'd0);
    check("abort_ready", 64'(bus1.o_ready),      64'd0);
    check("abort_ovr",   64'(bus1.o_overrun),    64'd1);
    check("abort_wcnt",  64'(bus1.o_word_count), 64'd2);
    pulse(1, 1'b1, 1'b0);
    check("restart_wcnt", 64'(bus1.o_word_count), 64'd0);
    check("restart_ovr",  64'(bus1.o_overrun),    64'd0);
    send_word(1, 32'hAABBCCDD, 32'd0);

    // Asynchronous reset mid-word clears outputs before the next edge
    @(posedge clk); #1;
    send_byte(1, 8'h77);
    send_byte(1, 8'h88);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulse(1, 1'b1, 1'b0);
    send_word(1, 32'h11223344, 32'd0);
    @(posedge clk); #1;
    check("post_rst_wcnt", 64'(bus1.o_word_count), 64'd1);

    // Small memory fills up without wrap-around
    pulse(2, 1'b1, 1'b0);
    send_word(2, 32'h10000000, 32'd0);
    send_word(2, 32'h20000000, 32'd1);
    send_word(2, 32'h30000000, 32'd2);
    send_word(2, 32'h40000000, 32'd3);
    @(posedge clk); #1;
    check("full_done", 64'(bus2.o_done),       64'd1);
    check("full_wcnt", 64'(bus2.o_word_count), 64'd4);
    check("full_busy", 64'(bus2.o_busy),       64'd0);
    send_byte(2, 8'h50);
    send_byte(2, 8'h60);
    send_byte(2, 8'h70);
    send_byte(2, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    check("full_still_done", 64'(bus2.o_done), 64'd1);

    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
